// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state encoding, frame geometry and the
// bit-period helper used by both the transmitter and the future receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   localparam int UART_DATA_BITS = 8;

   function automatic int uart_bit_cycles(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Clearable bit-period counter; o_tc marks the last clock of a bit period.
module uart_baud_cnt #(
   parameter int BIT_CYCLES = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   output logic o_tc
);

   localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(BIT_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;

   // Count clocks within the current bit; the owner clears on every transition.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= {CNT_W{1'b0}};
      end else if (i_clr) begin
         r_cnt <= {CNT_W{1'b0}};
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/uart_fifo_tx.sv
// UART 8N1 transmitter that pops bytes from a FIFO read port and
// serializes them LSB first on a registered, idle-high tx line.
module uart_fifo_tx
   import uart_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_rdata,
   output logic       fifo_pop,
   output logic       tx,
   output logic       tx_busy
);

   localparam int BIT_CYCLES = uart_bit_cycles(CLK_HZ, BAUD);

   generate
      if ((CLK_HZ < BAUD) || ((CLK_HZ % BAUD) != 0)) begin : g_bad_cfg
         $error("uart_fifo_tx: CLK_HZ must be a multiple of BAUD and >= BAUD");
      end
   endgenerate

   uart_state_e r_state;
   uart_state_e w_state_nxt;
   logic [7:0]  r_shreg;
   logic [7:0]  w_shreg_nxt;
   logic [2:0]  r_bit_cnt;
   logic [2:0]  w_bit_cnt_nxt;
   logic        r_tx;
   logic        w_tx_nxt;
   logic        w_tc;
   logic        w_clr;

   // The counter is held at zero in IDLE so the start bit gets a full period.
   assign w_clr = (r_state == ST_IDLE) | w_tc;

   uart_baud_cnt #(
      .BIT_CYCLES(BIT_CYCLES)
   ) u_baud_cnt (
      .i_clk(clk),
      .i_rst(rst),
      .i_clr(w_clr),
      .o_tc (w_tc)
   );

   // State, shift register, bit counter and line register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_shreg   <= 8'h00;
         r_bit_cnt <= 3'd0;
         r_tx      <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_shreg   <= w_shreg_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_tx      <= w_tx_nxt;
      end
   end

   // Frame sequencing; the FIFO is only looked at while IDLE.
   always_comb begin
      w_state_nxt   = r_state;
      w_shreg_nxt   = r_shreg;
      w_bit_cnt_nxt = r_bit_cnt;
      w_tx_nxt      = r_tx;
      case (r_state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               w_shreg_nxt = fifo_rdata;
               w_tx_nxt    = 1'b0;
               w_state_nxt = ST_START;
            end else begin
               w_tx_nxt    = 1'b1;
            end
         end
         ST_START: begin
            if (w_tc) begin
               w_tx_nxt      = r_shreg[0];
               w_bit_cnt_nxt = 3'd0;
               w_state_nxt   = ST_DATA;
            end else begin
               w_tx_nxt      = 1'b0;
            end
         end
         ST_DATA: begin
            if (w_tc && (r_bit_cnt == 3'(UART_DATA_BITS - 1))) begin
               w_tx_nxt    = 1'b1;
               w_state_nxt = ST_STOP;
            end else if (w_tc) begin
               w_shreg_nxt   = {1'b0, r_shreg[7:1]};
               w_tx_nxt      = r_shreg[1];
               w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            end else begin
               w_tx_nxt      = r_tx;
            end
         end
         ST_STOP: begin
            if (w_tc) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_STOP;
            end
            w_tx_nxt = 1'b1;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_tx_nxt    = 1'b1;
         end
      endcase
   end

   assign fifo_pop = ~rst & ~fifo_empty & (r_state == ST_IDLE);
   assign tx       = r_tx;
   assign tx_busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Directed bench for uart_fifo_tx: a frame-level line model checked every
// cycle on two instances (4 and 1 clocks per bit), plus literal expectations.
module tb_uart_fifo_tx;

   logic            clk;
   logic [1:0]      rst_s;
   logic [1:0]      empty_s;
   logic [1:0][7:0] rdata_s;
   logic [1:0]      pop_w;
   logic [1:0]      tx_w;
   logic [1:0]      busy_w;

   int checks;
   int errors;
   int cyc;
   bit chk_en;
   bit rand_en;
   bit found;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] junk;

   // Model: frame bits and clocks remaining in the frame, per instance.
   int         left_m[2];
   int         bc_m[2];
   logic [9:0] frame_m[2];

   uart_fifo_tx #(.CLK_HZ(1_000_000), .BAUD(250_000)) dut0 (
      .clk(clk), .rst(rst_s[0]), .fifo_empty(empty_s[0]), .fifo_rdata(rdata_s[0]),
      .fifo_pop(pop_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0])
   );

   uart_fifo_tx #(.CLK_HZ(1_000_000), .BAUD(1_000_000)) dut1 (
      .clk(clk), .rst(rst_s[1]), .fifo_empty(empty_s[1]), .fifo_rdata(rdata_s[1]),
      .fifo_pop(pop_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_pop(input int i, input int maxc, input string name);
      found = 1'b0;
      for (int c = 0; c < maxc; c++) begin
         @(negedge clk);
         if (pop_w[i]) begin
            found = 1'b1;
            break;
         end
      end
      chk(name, 32'(found), 32'd1);
   endtask

   logic [9:0] samp;
   int         busy_cnt;
   int         c0;
   int         npop;
   int         bad;

   initial begin
      checks  = 0;
      errors  = 0;
      cyc     = 0;
      chk_en  = 1'b0;
      rand_en = 1'b0;
      rst_s   = 2'b11;
      empty_s = 2'b11;
      rdata_s = '0;
      bc_m[0] = 4;
      bc_m[1] = 1;
      left_m[0] = 0;
      left_m[1] = 0;
      frame_m[0] = 10'h3FF;
      frame_m[1] = 10'h3FF;

      fork
         // Model update at each edge from the inputs the DUT sees.
         forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
               if (rst_s[i]) begin
                  left_m[i] = 0;
               end else if (left_m[i] > 0) begin
                  left_m[i] = left_m[i] - 1;
               end else if (!empty_s[i]) begin
                  left_m[i]  = 10 * bc_m[i];
                  frame_m[i] = {1'b1, rdata_s[i], 1'b0};
               end
            end
         end
         // FIFO model: pop on strobe, present head shortly after the edge.
         forever begin
            @(posedge clk);
            if (pop_w[0] && q0.size() > 0) junk = q0.pop_front();
            if (pop_w[1] && q1.size() > 0) junk = q1.pop_front();
            #1;
            empty_s[0] = (q0.size() == 0) || (rand_en && ($urandom_range(0, 1) == 1));
            rdata_s[0] = empty_s[0] ? 8'($urandom) : q0[0];
            empty_s[1] = (q1.size() == 0);
            rdata_s[1] = empty_s[1] ? 8'h00 : q1[0];
         end
         // Per-cycle comparison against the model.
         forever begin
            @(negedge clk);
            if (chk_en) begin
               for (int i = 0; i < 2; i++) begin
                  chk($sformatf("model_pop%0d", i), 32'(pop_w[i]),
                      32'(!rst_s[i] && !empty_s[i] && left_m[i] == 0));
                  chk($sformatf("model_busy%0d", i), 32'(busy_w[i]), 32'(left_m[i] != 0));
                  chk($sformatf("model_tx%0d", i), 32'(tx_w[i]),
                      (left_m[i] == 0) ? 32'd1 :
                      32'(frame_m[i][(10 * bc_m[i] - left_m[i]) / bc_m[i]]));
               end
            end
         end
      join_none

      // 1: reset held with a non-empty FIFO
      q0.push_back(8'hA5);
      @(posedge clk);
      #1 chk_en = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("rst_tx", 32'(tx_w[0]), 32'd1);
         chk("rst_busy", 32'(busy_w[0]), 32'd0);
         chk("rst_pop", 32'(pop_w[0]), 32'd0);
      end
      @(posedge clk);
      #1 rst_s = 2'b00;

      // 2: single byte 0xA5, mid-bit samples and busy length
      wait_pop(0, 10, "s2_pop");
      samp = '0;
      busy_cnt = 0;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         if (busy_w[0]) busy_cnt++;
         if (c >= 3 && ((c - 3) % 4) == 0 && ((c - 3) / 4) < 10) samp[(c - 3) / 4] = tx_w[0];
      end
      chk("s2_bits", 32'(samp), 32'(10'b1101001010));
      chk("s2_busy_len", 32'(busy_cnt), 32'd40);

      // 3: back-to-back 0x00 then 0xFF
      q0.push_back(8'h00);
      q0.push_back(8'hFF);
      wait_pop(0, 5, "s3_pop1");
      c0 = cyc;
      wait_pop(0, 60, "s3_pop2");
      chk("s3_pop_gap", 32'(cyc - c0), 32'd41);
      chk("s3_gap_tx", 32'(tx_w[0]), 32'd1);
      repeat (45) @(negedge clk);

      // 4: reset mid-frame
      q0.push_back(8'hB7);
      q0.push_back(8'h5E);
      wait_pop(0, 5, "s4_pop1");
      repeat (14) @(posedge clk);
      #1 rst_s[0] = 1'b1;
      @(negedge clk);
      repeat (3) begin
         @(negedge clk);
         chk("s4_rst_pop", 32'(pop_w[0]), 32'd0);
         chk("s4_rst_busy", 32'(busy_w[0]), 32'd0);
         chk("s4_rst_tx", 32'(tx_w[0]), 32'd1);
      end
      @(posedge clk);
      #1 rst_s[0] = 1'b0;
      @(negedge clk);
      chk("s4_pop_after_release", 32'(pop_w[0]), 32'd1);
      repeat (45) @(negedge clk);

      // 5: empty flag toggling randomly
      q0.push_back(8'h12);
      q0.push_back(8'h34);
      q0.push_back(8'h56);
      rand_en = 1'b1;
      npop = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (pop_w[0]) npop++;
         if (q0.size() == 0 && !busy_w[0] && !pop_w[0]) break;
      end
      rand_en = 1'b0;
      chk("s5_pop_count", 32'(npop), 32'd3);
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (tx_w[0] !== 1'b1) bad++;
      end
      chk("s5_idle_line", 32'(bad), 32'd0);

      // 6: one clock per bit, byte 0x3C
      q1.push_back(8'h3C);
      q1.push_back(8'h81);
      wait_pop(1, 5, "s6_pop1");
      samp = '0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         samp[k] = tx_w[1];
      end
      chk("s6_bits", 32'(samp), 32'(10'b1001111000));
      @(negedge clk);
      chk("s6_pop_period", 32'(pop_w[1]), 32'd1);
      repeat (15) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_fifo_tx.md
# uart_fifo_tx

UART 8N1 transmitter that drains the byte FIFO from its read side. It sits between the TX FIFO (pop/empty/pop_data port) and the board-level `tx` pin. Whenever the FIFO is non-empty and the line is idle, it pops one byte and serializes it LSB first at a fixed baud rate. Sensor readings and ASCII formatting upstream only ever push into the FIFO; this block owns all line timing.

## Interface
- `CLK_HZ`, default 100_000_000, system clock frequency in Hz.
- `BAUD`, default 9600, line rate in bit/s. `CLK_HZ % BAUD == 0` and `CLK_HZ >= BAUD` are required; elaboration fails otherwise.
- `clk`  in  1  system clock. One clock domain only.
- `rst`  in  1  reset, synchronous, active-high.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rdata`  in  8  FIFO head data. Combinational; valid whenever `fifo_empty == 0`.
- `fifo_pop`  out  1  one-cycle pop strobe to the FIFO.
- `tx`  out  1  serial line, idles high, registered.
- `tx_busy`  out  1  high while a frame is in progress.

## Operation
- Derived constants:
  - `BIT_CYCLES = CLK_HZ / BAUD`.
  - Baud counter width `$clog2(BIT_CYCLES)`, minimum 1.
  - 3-bit data-bit counter.
  - 8-bit shift register.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - `fifo_pop = ~rst & ~fifo_empty`. This is the only combinational output.
  - When `fifo_empty == 0` at a clock edge: latch `fifo_rdata` into the shift register, clear the baud counter, set `tx <= 0`, go to START.
- START: hold `tx = 0` for `BIT_CYCLES` clocks. At terminal count (`BIT_CYCLES-1`): `tx <= shreg[0]`, bit counter <= 0, go to DATA.
- DATA: each bit is held `BIT_CYCLES` clocks. At terminal count:
  - If bit counter == 7: `tx <= 1`, go to STOP.
  - Else: shift right, `tx <=` next bit, increment bit counter.
- STOP: hold `tx = 1` for `BIT_CYCLES` clocks. At terminal count, go to IDLE.
- `tx_busy = (state != IDLE)`. Decoded from the state register.
- `fifo_empty` and `fifo_rdata` are ignored outside IDLE. Exactly one pop per frame.
- The baud counter restarts at 0 on every state or bit transition. There is no free-running tick.

## Timing
- Reset values: `tx = 1`, `tx_busy = 0`, `fifo_pop = 0`, state IDLE, counters 0, shift register 0.
- Pop-to-line latency: `fifo_pop` is high in cycle N. `tx` falls and `tx_busy` rises in cycle N+1.
- Frame length: 10·`BIT_CYCLES` clocks from `tx` fall to the return to IDLE.
- Back-to-back bytes: one IDLE clock between frames (the pop cycle). Consecutive pops are exactly 10·`BIT_CYCLES`+1 clocks apart.
- The FIFO's empty flag updates on the edge after the pop. Because the state has left IDLE by then, no double pop is possible.
- Reset mid-frame: on the first edge with `rst` high, return to IDLE with `tx = 1`. The in-flight byte is lost and not re-popped. No pop while `rst` is high, even if the FIFO is non-empty.
- `BIT_CYCLES == 1`: every state lasts one clock. The frame is 10 clocks and the pop period is 11 clocks.

## Structure
- Shared package `uart_pkg`:
  - State encoding: IDLE = 0, START = 1, DATA = 2, STOP = 3.
  - `UART_DATA_BITS = 8`.
  - A constant function for `BIT_CYCLES`, reused by the future receiver.
- One natural sub-module: `uart_baud_cnt`, a clearable counter with a terminal-count output, parameterized by `BIT_CYCLES`. The FSM, shift register and bit counter stay in the top module.
- Integration: instantiated next to `fifo`, wired as follows:
  - `fifo_pop` → `pop`
  - `pop_data` → `fifo_rdata`
  - `empty` → `fifo_empty`

## Test plan
Bench parameters: `CLK_HZ = 1_000_000`, `BAUD = 250_000` (`BIT_CYCLES = 4`), except scenario 6.
1. Reset: `rst` high for 3 clocks with `fifo_empty = 0` → `tx = 1`, `tx_busy = 0`, `fifo_pop = 0` throughout.
2. Single byte 0xA5 with `fifo_empty` dropping once → one pop pulse. Sampling `tx` mid-bit every 4 clocks gives 0,1,0,1,0,0,1,0,1,1. `tx_busy` is high for exactly 40 clocks.
3. FIFO model preloaded with 0x00, 0xFF → two pops 41 clocks apart. Line shows a 0x00 frame, then an 0xFF frame. `tx = 1` during the 1-clock gap.
4. `rst` asserted at clock 15 of a frame → `tx = 1` and `tx_busy = 0` on the next edge. No pop while `rst` is high. A new frame with the next byte starts one clock after release.
5. `fifo_empty` toggled randomly during a frame → no extra pops, serialized data unchanged. With `fifo_empty` held at 1, `tx` stays 1 for 1000 clocks.
6. `CLK_HZ = BAUD` (`BIT_CYCLES = 1`), byte 0x3C → `tx` sequence 0,0,0,1,1,1,1,0,0,1 on consecutive clocks. Next pop occurs 11 clocks after the first.
